// File: rtl/line_window_col3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_window_col3                                                           |
// | Line-buffered raster stream to vertically aligned 3-pixel column (r-2..r). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module line_window_col3 #(
  parameter int DATA_WIDTH = 14,
  parameter int LINE_WIDTH = 256,
  localparam int COL_W     = $clog2(LINE_WIDTH - 1) + 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic [DATA_WIDTH-1:0] top_out,
  output logic [DATA_WIDTH-1:0] mid_out,
  output logic [DATA_WIDTH-1:0] bot_out,
  output logic                  out_valid,
  output logic [COL_W-1:0]      col_out,
  output logic                  out_eol,
  output logic                  sof_err
);

  localparam int               C_AW   = (LINE_WIDTH > 2) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [COL_W-1:0] C_LAST = COL_W'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_FILL0 = 2'd0,
    S_FILL1 = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [COL_W-1:0]      r_col;
  logic [COL_W-1:0]      w_col_eff;
  logic [COL_W-1:0]      w_col_nxt;
  logic                  w_line_end;
  logic [C_AW-1:0]       w_addr;

  logic [DATA_WIDTH-1:0] r_l1 [0:LINE_WIDTH-1];
  logic [DATA_WIDTH-1:0] r_l2 [0:LINE_WIDTH-1];

  logic [DATA_WIDTH-1:0] r_top;
  logic [DATA_WIDTH-1:0] r_mid;
  logic [DATA_WIDTH-1:0] r_bot;
  logic                  r_valid;
  logic [COL_W-1:0]      r_col_out;
  logic                  r_eol;
  logic                  r_sof_err;

  // A start-of-frame pixel always lands in column 0, whatever the counter says.
  assign w_col_eff  = in_sof ? '0 : r_col;
  assign w_line_end = (w_col_eff == C_LAST);
  assign w_addr     = w_col_eff[C_AW-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    if (in_valid) begin
      w_col_nxt = w_line_end ? '0 : w_col_eff + COL_W'(1);
      if (in_sof) begin
        w_state_nxt = S_FILL0;
      end else if (w_line_end) begin
        case (r_state)
          S_FILL0: w_state_nxt = S_FILL1;
          S_FILL1: w_state_nxt = S_RUN;
          S_RUN:   w_state_nxt = S_RUN;
          default: w_state_nxt = S_FILL0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_FILL0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Read-before-write: the output stage below samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_l2[w_addr] <= r_l1[w_addr];
      r_l1[w_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_top     <= '0;
      r_mid     <= '0;
      r_bot     <= '0;
      r_valid   <= 1'b0;
      r_col_out <= '0;
      r_eol     <= 1'b0;
      r_sof_err <= 1'b0;
    end else begin
      r_valid   <= in_valid && !in_sof && (r_state == S_RUN);
      r_sof_err <= in_valid && in_sof && (r_col != '0);
      if (in_valid) begin
        r_top     <= r_l2[w_addr];
        r_mid     <= r_l1[w_addr];
        r_bot     <= data_in;
        r_col_out <= w_col_eff;
        r_eol     <= w_line_end;
      end
    end
  end

  assign top_out   = r_top;
  assign mid_out   = r_mid;
  assign bot_out   = r_bot;
  assign out_valid = r_valid;
  assign col_out   = r_col_out;
  assign out_eol   = r_eol;
  assign sof_err   = r_sof_err;

endmodule
`default_nettype wire

// File: tb/tb_line_window_col3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_line_window_col3                                                        |
// | Directed self-checking bench: 4-wide instance plus a default 256-wide one. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_line_window_col3;

  logic        clk;
  logic        arstn;

  logic [13:0] data_in;
  logic        in_valid;
  logic        in_sof;
  logic [13:0] top4, mid4, bot4;
  logic        vld4, eol4, err4;
  logic [2:0]  col4;

  logic [13:0] d2;
  logic        v2;
  logic        s2;
  logic [13:0] top2, mid2, bot2;
  logic        vld2, eol2, err2;
  logic [8:0]  col2;

  int n_chk;
  int n_err;

  line_window_col3 #(.DATA_WIDTH(14), .LINE_WIDTH(4)) dut4 (
    .clk(clk), .arstn(arstn), .data_in(data_in), .in_valid(in_valid), .in_sof(in_sof),
    .top_out(top4), .mid_out(mid4), .bot_out(bot4), .out_valid(vld4),
    .col_out(col4), .out_eol(eol4), .sof_err(err4)
  );

  line_window_col3 #(.DATA_WIDTH(14), .LINE_WIDTH(256)) dut256 (
    .clk(clk), .arstn(arstn), .data_in(d2), .in_valid(v2), .in_sof(s2),
    .top_out(top2), .mid_out(mid2), .bot_out(bot2), .out_valid(vld2),
    .col_out(col2), .out_eol(eol2), .sof_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [13:0] d, input logic sof);
    data_in  = d;
    in_valid = 1'b1;
    in_sof   = sof;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // out_valid always checked; data fields only when a triple is expected.
  task automatic expect_out(input string tag, input logic v, input int t, input int m,
                            input int b, input int c, input logic e);
    check({tag, ".valid"}, 32'(vld4), 32'(v));
    if (v) begin
      check({tag, ".top"}, 32'(top4), 32'(t));
      check({tag, ".mid"}, 32'(mid4), 32'(m));
      check({tag, ".bot"}, 32'(bot4), 32'(b));
      check({tag, ".col"}, 32'(col4), 32'(c));
      check({tag, ".eol"}, 32'(eol4), 32'(e));
    end
  endtask

  initial begin
    int nv, neol, ncol, ndat, nvb;
    n_chk    = 0;
    n_err    = 0;
    arstn    = 1'b0;
    data_in  = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    d2       = '0;
    v2       = 1'b0;
    s2       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(vld4), 0);
    check("rst.top", 32'(top4), 0);
    check("rst.col", 32'(col4), 0);
    check("rst.sof_err", 32'(err4), 0);
    arstn = 1'b1;
    idle();

    // T1: contiguous 0..11, rows 2 give (p-8, p-4, p)
    for (int p = 0; p < 12; p++) begin
      push(14'(p), p == 0);
      expect_out("t1", p >= 8, p - 8, p - 4, p, p % 4, (p % 4) == 3);
      check("t1.sof_err", 32'(err4), 0);
    end
    idle();

    // T2: in_valid toggling; each result appears exactly one cycle after its accept
    for (int p = 0; p < 16; p++) begin
      push(14'(p + 20), p == 0);
      expect_out("t2", p >= 8, p + 12, p + 16, p + 20, p % 4, (p % 4) == 3);
      idle();
      check("t2.gap_valid", 32'(vld4), 0);
    end

    // T3: mid-line restart at column 2 of row 3
    for (int p = 0; p < 14; p++) begin
      push(14'(p), p == 0);
      expect_out("t3.pre", p >= 8, p - 8, p - 4, p, p % 4, (p % 4) == 3);
    end
    push(14'd100, 1'b1);
    check("t3.sof_err", 32'(err4), 1);
    check("t3.sof_valid", 32'(vld4), 0);
    idle();
    check("t3.sof_err_pulse", 32'(err4), 0);
    for (int k = 1; k <= 10; k++) begin
      push(14'(100 + k), 1'b0);
      expect_out("t3.post", k >= 8, 92 + k, 96 + k, 100 + k, k % 4, (k % 4) == 3);
      check("t3.post_err", 32'(err4), 0);
    end

    // T4: asynchronous reset mid-RUN, outputs clear without a clock edge
    arstn = 1'b0;
    #1;
    check("t4.valid", 32'(vld4), 0);
    check("t4.top", 32'(top4), 0);
    check("t4.mid", 32'(mid4), 0);
    check("t4.bot", 32'(bot4), 0);
    check("t4.col", 32'(col4), 0);
    check("t4.eol", 32'(eol4), 0);
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      push(14'(200 + k), 1'b0);
      expect_out("t4.post", k >= 8, 192 + k, 196 + k, 200 + k, k % 4, (k % 4) == 3);
    end

    // T5: full-scale / zero lines alternating
    for (int p = 0; p < 16; p++) begin
      logic [13:0] cur, prv;
      cur = ((p / 4) % 2 == 0) ? 14'h3FFF : 14'h0000;
      prv = ~cur;
      push(cur, p == 0);
      expect_out("t5", p >= 8, int'(cur), int'(prv), int'(cur), p % 4, (p % 4) == 3);
    end
    idle();

    // T6: 5 lines of 256 on the default-width instance
    nv = 0; neol = 0; ncol = 0; ndat = 0; nvb = 0;
    for (int p = 0; p < 1280; p++) begin
      d2 = 14'(p);
      v2 = 1'b1;
      s2 = (p == 0);
      @(posedge clk);
      #1;
      v2 = 1'b0;
      s2 = 1'b0;
      if (vld2 !== (p >= 512)) nvb++;
      if (vld2) begin
        nv++;
        if (eol2) neol++;
        if (32'(col2) != 32'(p % 256)) ncol++;
        if (32'(top2) != 32'(p - 512) || 32'(mid2) != 32'(p - 256) || 32'(bot2) != 32'(p)) ndat++;
      end
    end
    check("t6.valid_count", 32'(nv), 768);
    check("t6.eol_count", 32'(neol), 3);
    check("t6.col_seq_errs", 32'(ncol), 0);
    check("t6.data_errs", 32'(ndat), 0);
    check("t6.valid_timing_errs", 32'(nvb), 0);
    check("t6.last_top", 32'(top2), 767);
    check("t6.last_eol", 32'(eol2), 1);
    idle();
    check("t6.idle_valid", 32'(vld2), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
